fetch_unit: RTL and testbench

Instruction fetch front end for the single-cycle core. It owns the program counter and drives the read side of the instruction memory, whose synchronous read returns data one cycle after the address is presented. Returned words are buffered in a 2-entry queue and handed to decode over a valid/ready handshake. A redirect port lets execute steer the PC on taken branches and jumps.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 47 ++++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fetch_pkg;

  localparam int FETCH_QDEPTH = 2;
  localparam int INSTR_BYTES  = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, instr} entries sitting between imem and decode.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: none internally; the fetch unit's credit rule keeps push off when full.
// Ports: clk, rst_n, flush (drops all entries, beats push), push/push_entry,
//        pop, head (oldest entry), count (entries held, 0..2).
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [FETCH_QDEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FETCH_QDEPTH; i++) mem[i] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else if (flush) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues imem reads, queues returned words for decode.
// Latency: request in N, imem data in N+1, out_valid in N+2; redirect target valid in N+3.
// Backpressure: issues only while queued + in-flight words leave a free slot; out_ready low stalls fetch.
// Ports: clk, rst_n; imem_addr/imem_req/imem_rdata (synchronous-read memory);
//        redirect_valid/redirect_pc (from execute); out_valid/out_ready/out_instr/out_pc
//        (to decode); fault (misaligned redirect seen).
// Build option: FETCH_ALIGN_CHECK_EN -- when defined a misaligned redirect parks the
//        unit in FAULT until reset; otherwise the low two target bits are dropped.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault
);

  fetch_state_t state;
  logic [31:0]  pc_q;
  logic [31:0]  req_pc_q;
  logic         inflight_q;

  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic [1:0]   count;
  logic [2:0]   occ;
  logic         pop;
  logic         push;
  logic         redir;
  logic         misaligned;
  logic [31:0]  redir_target;
  logic         issue;

  always_comb begin
    pop   = out_valid && out_ready;
    redir = (state == RUN) && redirect_valid;
`ifdef FETCH_ALIGN_CHECK_EN
    misaligned   = (redirect_pc[1:0] != 2'b00);
    redir_target = redirect_pc;
`else
    misaligned   = 1'b0;
    redir_target = redirect_pc & 32'hFFFF_FFFC;
`endif
    // Slots already spoken for: queued words plus the response due next
    // cycle, less the word decode takes this cycle.
    occ   = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    issue = (state == RUN) && !redir && (occ < 3'(QDEPTH));
    // Redirect blocks the push, and since it also blocks issue there is
    // never a response arriving in the cycle after a redirect.
    push  = (state == RUN) && inflight_q && !redir;
    push_entry = '{pc: req_pc_q, instr: imem_rdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc_q       <= RESET_PC;
      req_pc_q   <= 32'h0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) req_pc_q <= pc_q;
      case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (redir) begin
            if (misaligned) state <= FAULT;
            else            pc_q  <= redir_target;
          end else if (issue) begin
            pc_q <= pc_q + 32'(INSTR_BYTES);
          end
        end
        FAULT:   state <= FAULT;
        default: state <= IDLE;
      endcase
    end
  end

  fetch_queue u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redir),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  assign imem_addr = pc_q;
  assign imem_req  = issue;
  assign out_valid = (count != 2'd0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
`ifdef FETCH_ALIGN_CHECK_EN
  assign fault = (state == FAULT);
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_pc;   // model: pc of the next word decode must receive

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .QDEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fault(fault)
  );

  // Memory contents: word i holds 0x1000 + i.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  // Synchronous-read instruction memory.
  always @(posedge clk) if (imem_req) imem_rdata <= mem_word(imem_addr);

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    adv(); adv(); sample();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    total++; if (imem_addr !== RST_PC) begin bad++; $display("FAIL rst_addr got=%h exp=%h", imem_addr, RST_PC); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", out_instr); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", out_pc); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%b exp=0", fault); end
    adv(); rst_n = 1'b1;
    sample();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL idle_req got=%b exp=0", imem_req); end
    adv(); sample();
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL first_req got=%b exp=1", imem_req); end
    total++; if (imem_addr !== RST_PC) begin bad++; $display("FAIL first_addr got=%h exp=%h", imem_addr, RST_PC); end
    adv(); sample();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL early_valid got=%b exp=0", out_valid); end
    adv(); sample();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b exp=1", out_valid); end
    total++; if (out_pc !== RST_PC) begin bad++; $display("FAIL first_pc got=%h exp=%h", out_pc, RST_PC); end
    total++; if (out_instr !== 32'h1000) begin bad++; $display("FAIL first_instr got=%h exp=00001000", out_instr); end
    exp_pc = RST_PC + 32'd4;
    adv();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 10; i++) begin
      sample();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid got=%b exp=1", out_valid); end
      total++; if (out_pc !== exp_pc) begin bad++; $display("FAIL stream_pc got=%h exp=%h", out_pc, exp_pc); end
      total++; if (out_instr !== mem_word(exp_pc)) begin bad++; $display("FAIL stream_instr got=%h exp=%h", out_instr, mem_word(exp_pc)); end
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL stream_req got=%b exp=1", imem_req); end
      exp_pc += 32'd4;
      adv();
    end
  endtask

  task automatic test_backpressure();
    int nreq = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      if (imem_req) nreq++;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b exp=1", out_valid); end
      total++; if (out_pc !== exp_pc) begin bad++; $display("FAIL stall_pc got=%h exp=%h", out_pc, exp_pc); end
      total++; if (out_instr !== mem_word(exp_pc)) begin bad++; $display("FAIL stall_instr got=%h exp=%h", out_instr, mem_word(exp_pc)); end
      adv();
    end
    sample();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_full_req got=%b exp=0", imem_req); end
    total++; if (nreq > 2) begin bad++; $display("FAIL stall_reqs got=%0d exp<=2", nreq); end
    adv();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sample();
      if (i == 0) begin
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL release_req got=%b exp=1", imem_req); end
      end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL release_valid got=%b exp=1", out_valid); end
      total++; if (out_pc !== exp_pc) begin bad++; $display("FAIL release_pc got=%h exp=%h", out_pc, exp_pc); end
      total++; if (out_instr !== mem_word(exp_pc)) begin bad++; $display("FAIL release_instr got=%h exp=%h", out_instr, mem_word(exp_pc)); end
      exp_pc += 32'd4;
      adv();
    end
  endtask

  // Redirect while decode stalls: one word queued and one response arriving.
  task automatic test_redirect_full();
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    sample();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL redir_req_n got=%b exp=0", imem_req); end
    adv();
    redirect_valid = 1'b0; out_ready = 1'b1; exp_pc = 32'h40;
    sample();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_valid_n1 got=%b exp=0", out_valid); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL redir_req_n1 got=%b exp=1", imem_req); end
    total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL redir_addr_n1 got=%h exp=00000040", imem_addr); end
    adv(); sample();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_valid_n2 got=%b exp=0", out_valid); end
    adv();
    for (int i = 0; i < 5; i++) begin
      sample();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL redir_stream_valid got=%b exp=1", out_valid); end
      total++; if (out_pc !== exp_pc) begin bad++; $display("FAIL redir_stream_pc got=%h exp=%h", out_pc, exp_pc); end
      total++; if (out_instr !== mem_word(exp_pc)) begin bad++; $display("FAIL redir_stream_instr got=%h exp=%h", out_instr, mem_word(exp_pc)); end
      exp_pc += 32'd4;
      adv();
    end
  endtask

  // Pop and redirect together; target near the top of memory to exercise wrap.
  task automatic test_pop_redirect();
    logic found = 1'b0;
    int   waited = 0;
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    sample();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL popredir_valid got=%b exp=1", out_valid); end
    total++; if (out_pc !== exp_pc) begin bad++; $display("FAIL popredir_pc got=%h exp=%h", out_pc, exp_pc); end
    exp_pc = 32'hFFFF_FFF8;
    adv();
    redirect_valid = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      sample();
      if (out_valid) begin
        found = 1'b1;
        total++; if (out_pc !== exp_pc) begin bad++; $display("FAIL popredir_target_pc got=%h exp=%h", out_pc, exp_pc); end
        total++; if (out_instr !== mem_word(exp_pc)) begin bad++; $display("FAIL popredir_target_instr got=%h exp=%h", out_instr, mem_word(exp_pc)); end
        exp_pc += 32'd4;
      end else begin
        waited++;
      end
      adv();
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL popredir_timeout got=%b exp=1", found); end
    total++; if (waited != 2) begin bad++; $display("FAIL popredir_gap got=%0d exp=2", waited); end
    for (int i = 0; i < 4; i++) begin
      sample();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%b exp=1", out_valid); end
      total++; if (out_pc !== exp_pc) begin bad++; $display("FAIL wrap_pc got=%h exp=%h", out_pc, exp_pc); end
      total++; if (out_instr !== mem_word(exp_pc)) begin bad++; $display("FAIL wrap_instr got=%h exp=%h", out_instr, mem_word(exp_pc)); end
      exp_pc += 32'd4;
      adv();
    end
  endtask

  task automatic test_misalign();
    logic        found = 1'b0;
    logic [31:0] fault_pc;
    // Steady stream: head is exp_pc, one word in flight, next fetch exp_pc+8.
    fault_pc = exp_pc + 32'd8;
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h42;
    sample();
    total++; if (out_pc !== exp_pc) begin bad++; $display("FAIL mis_pop_pc got=%h exp=%h", out_pc, exp_pc); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL mis_req_n got=%b exp=0", imem_req); end
    adv();
    redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      sample();
      total++; if (fault !== 1'b1) begin bad++; $display("FAIL mis_fault got=%b exp=1", fault); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL mis_req got=%b exp=0", imem_req); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mis_valid got=%b exp=0", out_valid); end
      total++; if (imem_addr !== fault_pc) begin bad++; $display("FAIL mis_addr got=%h exp=%h", imem_addr, fault_pc); end
      adv();
    end
    rst_n = 1'b0;
    #1;
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL mis_reset_fault got=%b exp=0", fault); end
    adv(); adv();
    rst_n = 1'b1;
    exp_pc = RST_PC;
`else
    sample();
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL nomis_fault got=%b exp=0", fault); end
    total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL nomis_addr got=%h exp=00000040 (was %h)", imem_addr, fault_pc); end
    adv();
    exp_pc = 32'h40;
`endif
    for (int i = 0; i < 8 && !found; i++) begin
      sample();
      if (out_valid) begin
        found = 1'b1;
        total++; if (out_pc !== exp_pc) begin bad++; $display("FAIL mis_resume_pc got=%h exp=%h", out_pc, exp_pc); end
        total++; if (out_instr !== mem_word(exp_pc)) begin bad++; $display("FAIL mis_resume_instr got=%h exp=%h", out_instr, mem_word(exp_pc)); end
        exp_pc += 32'd4;
      end
      adv();
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL mis_resume_timeout got=%b exp=1", found); end
  endtask

  task automatic test_async_reset();
    logic found = 1'b0;
    logic req_seen = 1'b0;
    int   req_cyc = -1;
    out_ready = 1'b1; redirect_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL arst_req got=%b exp=0", imem_req); end
    total++; if (imem_addr !== RST_PC) begin bad++; $display("FAIL arst_addr got=%h exp=%h", imem_addr, RST_PC); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL arst_pc got=%h exp=0", out_pc); end
    total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL arst_instr got=%h exp=0", out_instr); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL arst_fault got=%b exp=0", fault); end
    adv(); adv();
    rst_n = 1'b1;
    exp_pc = RST_PC;
    for (int i = 0; i < 8 && !found; i++) begin
      sample();
      if (imem_req && !req_seen) begin
        req_seen = 1'b1;
        req_cyc  = i;
        total++; if (imem_addr !== RST_PC) begin bad++; $display("FAIL arst_first_addr got=%h exp=%h", imem_addr, RST_PC); end
      end
      if (out_valid) begin
        found = 1'b1;
        total++; if (out_pc !== exp_pc) begin bad++; $display("FAIL arst_first_pc got=%h exp=%h", out_pc, exp_pc); end
        total++; if (out_instr !== mem_word(exp_pc)) begin bad++; $display("FAIL arst_first_instr got=%h exp=%h", out_instr, mem_word(exp_pc)); end
        exp_pc += 32'd4;
      end
      adv();
    end
    total++; if (req_cyc != 1) begin bad++; $display("FAIL arst_req_cycle got=%0d exp=1", req_cyc); end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL arst_timeout got=%b exp=1", found); end
  endtask

  // Random ready and aligned redirects; the delivered stream must follow the model.
  task automatic test_random();
    int accepted = 0;
    for (int i = 0; i < 400; i++) begin
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      sample();
      if (out_valid) begin
        total++; if (out_pc !== exp_pc) begin bad++; $display("FAIL rand_pc cyc=%0d got=%h exp=%h", i, out_pc, exp_pc); end
        total++; if (out_instr !== mem_word(exp_pc)) begin bad++; $display("FAIL rand_instr cyc=%0d got=%h exp=%h", i, out_instr, mem_word(exp_pc)); end
        if (out_ready) begin
          accepted++;
          exp_pc += 32'd4;
        end
      end
      if (redirect_valid) exp_pc = redirect_pc;
      adv();
    end
    redirect_valid = 1'b0;
    total++; if (accepted < 100) begin bad++; $display("FAIL rand_progress got=%0d exp>=100", accepted); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_pop_redirect();
    test_misalign();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
